// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle control unit: steps each instruction through IF/ID/EXE/MEM/WB and
// drives the datapath enables. Only State and Halted are registered.
module multi_cycle_control_unit #(
  parameter int unsigned OP_W    = 6,
  parameter int unsigned ALUOP_W = 3,
  parameter int unsigned STATE_W = 3
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [OP_W-1:0]    Op,
  input  logic               zero,
  output logic               PCWre,
  output logic               IRWre,
  output logic               InsMemRW,
  output logic               ALUSrcA,
  output logic               ALUSrcB,
  output logic               ExtSel,
  output logic [1:0]         RegDst,
  output logic               RegWre,
  output logic               WrRegDSrc,
  output logic               DBDataSrc,
  output logic               mRD,
  output logic               mWR,
  output logic [1:0]         PCSrc,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [STATE_W-1:0] State,
  output logic               Halted
);

  typedef enum logic [STATE_W-1:0] {
    S_IF     = STATE_W'(0),
    S_ID     = STATE_W'(1),
    S_EXE_LS = STATE_W'(2),
    S_MEM    = STATE_W'(3),
    S_WB_LD  = STATE_W'(4),
    S_EXE_BR = STATE_W'(5),
    S_EXE_AL = STATE_W'(6),
    S_WB_AL  = STATE_W'(7)
  } state_t;

  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(6'b000001);
  localparam logic [OP_W-1:0] OP_ADDIU = OP_W'(6'b000010);
  localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(6'b010000);
  localparam logic [OP_W-1:0] OP_AND   = OP_W'(6'b010001);
  localparam logic [OP_W-1:0] OP_ORI   = OP_W'(6'b010010);
  localparam logic [OP_W-1:0] OP_OR    = OP_W'(6'b010011);
  localparam logic [OP_W-1:0] OP_SLL   = OP_W'(6'b011000);
  localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(6'b011100);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b100110);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100111);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b110000);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'b110001);
  localparam logic [OP_W-1:0] OP_BLTZ  = OP_W'(6'b110010);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b111000);
  localparam logic [OP_W-1:0] OP_JR    = OP_W'(6'b111001);
  localparam logic [OP_W-1:0] OP_JAL   = OP_W'(6'b111010);
  localparam logic [OP_W-1:0] OP_HALT  = OP_W'(6'b111111);

  state_t r_state;
  state_t w_next;
  logic   r_halted;

  logic [ALUOP_W-1:0] w_aluop;
  logic               w_srca;
  logic               w_srcb;
  logic               w_ext;
  logic               w_is_alu;
  logic               w_is_imm;
  logic               w_is_br;
  logic               w_is_ls;
  logic               w_taken;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state  <= S_IF;
      r_halted <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_ID && Op == OP_HALT) r_halted <= 1'b1;
    end
  end

  assign State  = r_state;
  assign Halted = r_halted;

  // Opcode decode: ALU controls and instruction class.
  always_comb begin
    w_aluop  = ALUOP_W'(3'b000);
    w_srca   = 1'b0;
    w_srcb   = 1'b0;
    w_ext    = 1'b0;
    w_is_alu = 1'b0;
    w_is_imm = 1'b0;
    w_is_br  = 1'b0;
    w_is_ls  = 1'b0;
    case (Op)
      OP_ADD:   begin w_is_alu = 1'b1; end
      OP_SUB:   begin w_is_alu = 1'b1; w_aluop = ALUOP_W'(3'b001); end
      OP_ADDIU: begin w_is_alu = 1'b1; w_is_imm = 1'b1; w_srcb = 1'b1; w_ext = 1'b1; end
      OP_ANDI:  begin w_is_alu = 1'b1; w_is_imm = 1'b1; w_srcb = 1'b1; w_aluop = ALUOP_W'(3'b100); end
      OP_AND:   begin w_is_alu = 1'b1; w_aluop = ALUOP_W'(3'b100); end
      OP_ORI:   begin w_is_alu = 1'b1; w_is_imm = 1'b1; w_srcb = 1'b1; w_aluop = ALUOP_W'(3'b011); end
      OP_OR:    begin w_is_alu = 1'b1; w_aluop = ALUOP_W'(3'b011); end
      OP_SLL:   begin w_is_alu = 1'b1; w_srca = 1'b1; w_aluop = ALUOP_W'(3'b010); end
      OP_SLTI:  begin
        w_is_alu = 1'b1; w_is_imm = 1'b1; w_srcb = 1'b1; w_ext = 1'b1;
        w_aluop  = ALUOP_W'(3'b110);
      end
      OP_SW, OP_LW:   begin w_is_ls = 1'b1; w_srcb = 1'b1; w_ext = 1'b1; end
      OP_BEQ, OP_BNE: begin w_is_br = 1'b1; w_aluop = ALUOP_W'(3'b001); end
      OP_BLTZ:  begin w_is_br = 1'b1; w_aluop = ALUOP_W'(3'b110); end
      default:  begin end
    endcase
  end

  always_comb begin
    w_taken = 1'b0;
    if (Op == OP_BEQ) w_taken = zero;
    else if (Op == OP_BNE || Op == OP_BLTZ) w_taken = ~zero;
  end

  // Next-state and output logic.
  always_comb begin
    w_next    = r_state;
    IRWre     = 1'b0;
    InsMemRW  = 1'b1;
    mRD       = 1'b1;
    mWR       = 1'b1;
    PCWre     = 1'b0;
    RegWre    = 1'b0;
    PCSrc     = 2'b00;
    RegDst    = 2'b00;
    WrRegDSrc = 1'b0;
    DBDataSrc = 1'b0;
    ALUOp     = ALUOP_W'(3'b000);
    ALUSrcA   = 1'b0;
    ALUSrcB   = 1'b0;
    ExtSel    = 1'b0;
    if (r_state != S_IF) begin
      ALUOp   = w_aluop;
      ALUSrcA = w_srca;
      ALUSrcB = w_srcb;
      ExtSel  = w_ext;
    end
    case (r_state)
      S_IF: begin
        IRWre  = 1'b1;
        w_next = S_ID;
      end
      S_ID: begin
        if (r_halted || Op == OP_HALT) begin
          w_next = S_ID;
        end else if (Op == OP_J || Op == OP_JAL) begin
          PCWre  = 1'b1;
          PCSrc  = 2'b11;
          RegWre = (Op == OP_JAL);
          w_next = S_IF;
        end else if (Op == OP_JR) begin
          PCWre  = 1'b1;
          PCSrc  = 2'b10;
          w_next = S_IF;
        end else if (w_is_br) begin
          w_next = S_EXE_BR;
        end else if (w_is_ls) begin
          w_next = S_EXE_LS;
        end else if (w_is_alu) begin
          w_next = S_EXE_AL;
        end else begin
          PCWre  = 1'b1;
          w_next = S_IF;
        end
      end
      S_EXE_AL: w_next = S_WB_AL;
      S_WB_AL: begin
        RegWre    = 1'b1;
        PCWre     = 1'b1;
        WrRegDSrc = 1'b1;
        RegDst    = w_is_imm ? 2'b01 : 2'b10;
        w_next    = S_IF;
      end
      S_EXE_BR: begin
        PCWre  = 1'b1;
        PCSrc  = w_taken ? 2'b01 : 2'b00;
        w_next = S_IF;
      end
      S_EXE_LS: w_next = S_MEM;
      S_MEM: begin
        if (Op == OP_SW) begin
          mWR    = 1'b0;
          PCWre  = 1'b1;
          w_next = S_IF;
        end else begin
          mRD    = 1'b0;
          w_next = S_WB_LD;
        end
      end
      S_WB_LD: begin
        RegWre    = 1'b1;
        RegDst    = 2'b01;
        DBDataSrc = 1'b1;
        WrRegDSrc = 1'b1;
        PCWre     = 1'b1;
        w_next    = S_IF;
      end
      default: w_next = S_IF;
    endcase
  end

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Directed bench for multi_cycle_control_unit: walks each instruction class
// cycle by cycle and checks state and control outputs against hand values.
module tb_multi_cycle_control_unit;

  logic       CLK = 1'b0;
  logic       Reset = 1'b1;
  logic [5:0] Op = 6'b000000;
  logic       zero = 1'b0;
  logic       PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, ExtSel;
  logic [1:0] RegDst;
  logic       RegWre, WrRegDSrc, DBDataSrc, mRD, mWR;
  logic [1:0] PCSrc;
  logic [2:0] ALUOp;
  logic [2:0] State;
  logic       Halted;

  int total = 0;
  int bad   = 0;

  multi_cycle_control_unit dut (
    .CLK(CLK), .Reset(Reset), .Op(Op), .zero(zero),
    .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ExtSel(ExtSel),
    .RegDst(RegDst), .RegWre(RegWre), .WrRegDSrc(WrRegDSrc),
    .DBDataSrc(DBDataSrc), .mRD(mRD), .mWR(mWR), .PCSrc(PCSrc),
    .ALUOp(ALUOp), .State(State), .Halted(Halted)
  );

  always #5 CLK = ~CLK;

  task automatic do_reset();
    @(negedge CLK); Reset = 1'b1;
    @(negedge CLK); Reset = 1'b0;
    #1;
  endtask

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({State, IRWre, InsMemRW, mRD, mWR, PCWre, RegWre, PCSrc, RegDst, ALUOp, Halted} !==
        {3'b000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 3'b000, 1'b0}) begin
      bad++; $display("FAIL reset_outputs: State=%b IRWre=%b PCWre=%b RegWre=%b", State, IRWre, PCWre, RegWre);
    end
    Op = 6'b000000;
    step(); step();
    total++;
    if (State !== 3'b110) begin bad++; $display("FAIL reach_exe_al: got %b want 110", State); end
    #1 Reset = 1'b1;
    #1;
    total++;
    if ({State, IRWre, PCWre, RegWre, Halted} !== {3'b000, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL async_reset: State=%b IRWre=%b PCWre=%b RegWre=%b", State, IRWre, PCWre, RegWre);
    end
    @(negedge CLK); Reset = 1'b0; #1;
    total++;
    if (State !== 3'b000) begin bad++; $display("FAIL reset_release: got %b want 000", State); end
  endtask

  task automatic test_add();
    logic [2:0] st [5] = '{3'b000, 3'b001, 3'b110, 3'b111, 3'b000};
    logic       we [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    Op = 6'b000000;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) step();
      total++;
      if ({State, RegWre, PCWre} !== {st[c], we[c], we[c]}) begin
        bad++; $display("FAIL add_cycle%0d: State=%b RegWre=%b PCWre=%b want %b %b", c, State, RegWre, PCWre, st[c], we[c]);
      end
      if (c == 3) begin
        total++;
        if ({RegDst, ALUOp, WrRegDSrc, DBDataSrc, ALUSrcB} !== {2'b10, 3'b000, 1'b1, 1'b0, 1'b0}) begin
          bad++; $display("FAIL add_wb: RegDst=%b ALUOp=%b WrRegDSrc=%b DBDataSrc=%b", RegDst, ALUOp, WrRegDSrc, DBDataSrc);
        end
      end
    end
  endtask

  task automatic test_alu_forms();
    logic [5:0] ops   [3] = '{6'b010010, 6'b011000, 6'b011100};
    logic [1:0] rd    [3] = '{2'b01, 2'b10, 2'b01};
    logic [2:0] aop   [3] = '{3'b011, 3'b010, 3'b110};
    logic       srca  [3] = '{1'b0, 1'b1, 1'b0};
    logic       srcb  [3] = '{1'b1, 1'b0, 1'b1};
    logic       ext   [3] = '{1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      Op = ops[k];
      step(); step(); step();
      total++;
      if ({State, RegWre, RegDst, ALUOp, ALUSrcA, ALUSrcB, ExtSel} !==
          {3'b111, 1'b1, rd[k], aop[k], srca[k], srcb[k], ext[k]}) begin
        bad++; $display("FAIL alu_form_%b: State=%b RegDst=%b ALUOp=%b A=%b B=%b Ext=%b", ops[k], State, RegDst, ALUOp, ALUSrcA, ALUSrcB, ExtSel);
      end
      step();
    end
  endtask

  task automatic test_lw();
    logic [2:0] st [6] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b000};
    logic       rd [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic       we [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    Op = 6'b100111;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) step();
      total++;
      if ({State, mRD, RegWre, PCWre, mWR} !== {st[c], rd[c], we[c], we[c], 1'b1}) begin
        bad++; $display("FAIL lw_cycle%0d: State=%b mRD=%b RegWre=%b PCWre=%b", c, State, mRD, RegWre, PCWre);
      end
      if (c == 4) begin
        total++;
        if ({DBDataSrc, RegDst, WrRegDSrc} !== {1'b1, 2'b01, 1'b1}) begin
          bad++; $display("FAIL lw_wb: DBDataSrc=%b RegDst=%b WrRegDSrc=%b", DBDataSrc, RegDst, WrRegDSrc);
        end
      end
    end
  endtask

  task automatic test_sw();
    Op = 6'b100110;
    step(); step(); step();
    total++;
    if ({State, mWR, mRD, PCWre, RegWre} !== {3'b011, 1'b0, 1'b1, 1'b1, 1'b0}) begin
      bad++; $display("FAIL sw_mem: State=%b mWR=%b mRD=%b PCWre=%b", State, mWR, mRD, PCWre);
    end
    step();
    total++;
    if (State !== 3'b000) begin bad++; $display("FAIL sw_return: got %b want 000", State); end
  endtask

  task automatic test_branch();
    logic [5:0] ops [5] = '{6'b110000, 6'b110000, 6'b110001, 6'b110001, 6'b110010};
    logic       z   [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [1:0] src [5] = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01};
    for (int k = 0; k < 5; k++) begin
      Op = ops[k]; zero = z[k];
      step();
      total++;
      if ({State, PCWre} !== {3'b001, 1'b0}) begin
        bad++; $display("FAIL br%0d_id: State=%b PCWre=%b", k, State, PCWre);
      end
      step();
      total++;
      if ({State, PCWre, PCSrc, RegWre} !== {3'b101, 1'b1, src[k], 1'b0}) begin
        bad++; $display("FAIL br%0d_exe: State=%b PCWre=%b PCSrc=%b want PCSrc=%b", k, State, PCWre, PCSrc, src[k]);
      end
      step();
      total++;
      if (State !== 3'b000) begin bad++; $display("FAIL br%0d_return: got %b", k, State); end
    end
    zero = 1'b0;
  endtask

  task automatic test_jump();
    logic [5:0] ops [4] = '{6'b111010, 6'b111000, 6'b111001, 6'b000011};
    logic [1:0] src [4] = '{2'b11, 2'b11, 2'b10, 2'b00};
    logic       we  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 4; k++) begin
      Op = ops[k];
      step();
      total++;
      if ({State, PCWre, PCSrc, RegWre, RegDst, WrRegDSrc} !== {3'b001, 1'b1, src[k], we[k], 2'b00, 1'b0}) begin
        bad++; $display("FAIL jump_%b: State=%b PCWre=%b PCSrc=%b RegWre=%b RegDst=%b WrRegDSrc=%b", ops[k], State, PCWre, PCSrc, RegWre, RegDst, WrRegDSrc);
      end
      step();
      total++;
      if (State !== 3'b000) begin bad++; $display("FAIL jump_%b_return: got %b", ops[k], State); end
    end
  endtask

  task automatic test_back_to_back();
    Op = 6'b111000;
    step(); step();
    Op = 6'b000001;
    step();
    total++;
    if ({State, ALUOp} !== {3'b001, 3'b001}) begin
      bad++; $display("FAIL b2b_sub_id: State=%b ALUOp=%b", State, ALUOp);
    end
    step(); step(); step();
    total++;
    if ({State, IRWre} !== {3'b000, 1'b1}) begin
      bad++; $display("FAIL b2b_return: State=%b IRWre=%b", State, IRWre);
    end
  endtask

  task automatic test_halt();
    Op = 6'b111111;
    step();
    total++;
    if ({State, Halted, PCWre, RegWre} !== {3'b001, 1'b0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL halt_id: State=%b Halted=%b PCWre=%b", State, Halted, PCWre);
    end
    step();
    Op = 6'b000000;
    for (int c = 0; c < 12; c++) begin
      total++;
      if ({State, Halted, PCWre, RegWre, IRWre, mRD, mWR} !== {3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
        bad++; $display("FAIL halt_hold%0d: State=%b Halted=%b PCWre=%b RegWre=%b", c, State, Halted, PCWre, RegWre);
      end
      step();
    end
    do_reset();
    total++;
    if ({State, Halted, IRWre} !== {3'b000, 1'b0, 1'b1}) begin
      bad++; $display("FAIL halt_reset: State=%b Halted=%b IRWre=%b", State, Halted, IRWre);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_alu_forms();
    test_lw();
    test_sw();
    test_branch();
    test_jump();
    test_back_to_back();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
